// File: rtl/hub75_plane_shifter.sv
// HUB75 column shifter: fetches pixel words, shifts one bit plane per row, then blanks/latches/unblanks.
// Define HUB75_ROW_DEADTIME_EN to hold BLANK 8 extra cycles before LAT whenever the row changes.
module hub75_plane_shifter #(
    parameter int ColorDepth = 4,
    parameter int Columns    = 64,
    parameter int Rows       = 16
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic                                    PLANE_DONE,
    input  logic [6*ColorDepth-1:0]                 PIX_DATA,
    output logic [$clog2(Rows)+$clog2(Columns)-1:0] PIX_ADDR,
    output logic                                    R1,
    output logic                                    G1,
    output logic                                    B1,
    output logic                                    R2,
    output logic                                    G2,
    output logic                                    B2,
    output logic                                    SCLK,
    output logic                                    LAT,
    output logic                                    BLANK,
    output logic [$clog2(Rows)-1:0]                 ROW_ADDR,
    output logic                                    PLANE_START,
    output logic [$clog2(ColorDepth)-1:0]           PLANE
);
    localparam int CW = $clog2(Columns);
    localparam int RW = $clog2(Rows);
    localparam int PW = $clog2(ColorDepth);

    localparam logic [2:0] ST_FETCH    = 3'd0;
    localparam logic [2:0] ST_SHIFT_LO = 3'd1;
    localparam logic [2:0] ST_SHIFT_HI = 3'd2;
    localparam logic [2:0] ST_WAIT     = 3'd3;
    localparam logic [2:0] ST_BLANK    = 3'd4;
    localparam logic [2:0] ST_LATCH    = 3'd5;
    localparam logic [2:0] ST_UNBLANK  = 3'd6;

    localparam logic [CW-1:0] LastCol   = CW'(Columns - 1);
    localparam logic [RW-1:0] LastRow   = RW'(Rows - 1);
    localparam logic [PW-1:0] LastPlane = PW'(ColorDepth - 1);

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [PW-1:0]         plane_q, plane_d;
    logic                  done_q, done_d;
    logic                  done_now;
    logic [ColorDepth-1:0] fld;
    logic [5:0]            rgb_d, rgb_q;
    logic                  sclk_q, lat_q, blank_q, start_q;
    logic [RW-1:0]         row_addr_q;
    logic [PW-1:0]         plane_out_q;
`ifdef HUB75_ROW_DEADTIME_EN
    logic [3:0]            dead_q, dead_d;
`endif

    // A pulse arriving in the same cycle as the decision counts immediately.
    assign done_now = done_q | PLANE_DONE;

    always_comb begin
        fld   = '0;
        rgb_d = '0;
        for (int k = 0; k < 6; k++) begin
            fld      = PIX_DATA[k*ColorDepth +: ColorDepth];
            rgb_d[k] = fld[plane_q];
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        plane_d = plane_q;
        done_d  = PLANE_DONE ? 1'b1 : done_q;
`ifdef HUB75_ROW_DEADTIME_EN
        dead_d  = dead_q;
`endif
        case (state_q)
            ST_FETCH:    state_d = ST_SHIFT_LO;
            ST_SHIFT_LO: state_d = ST_SHIFT_HI;
            ST_SHIFT_HI: begin
                if (col_q == LastCol) begin
                    state_d = done_now ? ST_BLANK : ST_WAIT;
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_WAIT:     if (done_now) state_d = ST_BLANK;
            ST_BLANK: begin
`ifdef HUB75_ROW_DEADTIME_EN
                if ((plane_q == LastPlane) && (dead_q != 4'd8)) begin
                    dead_d = dead_q + 1'b1;
                end else begin
                    dead_d  = '0;
                    state_d = ST_LATCH;
                end
`else
                state_d = ST_LATCH;
`endif
            end
            ST_LATCH:    state_d = ST_UNBLANK;
            ST_UNBLANK: begin
                // Clearing wins over a coincident PLANE_DONE pulse.
                done_d  = 1'b0;
                col_d   = '0;
                state_d = ST_FETCH;
                if (plane_q == LastPlane) begin
                    plane_d = '0;
                    row_d   = (row_q == LastRow) ? '0 : row_q + 1'b1;
                end else begin
                    plane_d = plane_q + 1'b1;
                end
            end
            default:     state_d = ST_FETCH;
        endcase
    end

    // Panel outputs are registered from the current state, one cycle behind it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_FETCH;
            col_q       <= '0;
            row_q       <= '0;
            plane_q     <= '0;
            done_q      <= 1'b1;
            sclk_q      <= 1'b0;
            lat_q       <= 1'b0;
            start_q     <= 1'b0;
            blank_q     <= 1'b1;
            rgb_q       <= '0;
            row_addr_q  <= '0;
            plane_out_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            done_q  <= done_d;
            sclk_q  <= (state_q == ST_SHIFT_HI);
            lat_q   <= (state_q == ST_LATCH);
            start_q <= (state_q == ST_UNBLANK);
            if (state_q == ST_BLANK) begin
                blank_q <= 1'b1;
            end else if (state_q == ST_UNBLANK) begin
                blank_q <= 1'b0;
            end
            if (state_q == ST_SHIFT_LO) begin
                rgb_q <= rgb_d;
            end
            if (state_q == ST_LATCH) begin
                row_addr_q  <= row_q;
                plane_out_q <= plane_q;
            end
        end
    end

`ifdef HUB75_ROW_DEADTIME_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            dead_q <= '0;
        end else begin
            dead_q <= dead_d;
        end
    end
`endif

    assign PIX_ADDR                 = {row_q, col_q};
    assign {R1, G1, B1, R2, G2, B2} = rgb_q;
    assign SCLK                     = sclk_q;
    assign LAT                      = lat_q;
    assign BLANK                    = blank_q;
    assign PLANE_START              = start_q;
    assign ROW_ADDR                 = row_addr_q;
    assign PLANE                    = plane_out_q;
endmodule

// File: tb/tb_hub75_plane_shifter.sv
// Directed bench for hub75_plane_shifter with Columns=4, ColorDepth=2, Rows=2 and a 1-cycle RAM model.
module tb_hub75_plane_shifter;
    localparam int CD   = 2;
    localparam int COLS = 4;
    localparam int ROWS = 2;
`ifdef HUB75_ROW_DEADTIME_EN
    localparam int DT = 8;
`else
    localparam int DT = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PLANE_DONE = 1'b0;
    logic [11:0] PIX_DATA;
    logic [2:0]  PIX_ADDR;
    logic        R1, G1, B1, R2, G2, B2;
    logic        SCLK, LAT, BLANK, PLANE_START;
    logic [0:0]  ROW_ADDR;
    logic [0:0]  PLANE;

    logic [11:0] mem [8];
    logic [5:0]  rgb;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          s, s2, s3;

    logic [63:0] sclk_m, lat_m, start_m, blank_m;
    int          sclk_n, lat_n, start_n, blank_n;
    logic [5:0]  rgb9;
    logic [2:0]  addr6, addr_s;
    logic [0:0]  plane_s, row_s;

    hub75_plane_shifter #(.ColorDepth(CD), .Columns(COLS), .Rows(ROWS)) dut (
        .CLK(CLK), .RST(RST), .PLANE_DONE(PLANE_DONE), .PIX_DATA(PIX_DATA),
        .PIX_ADDR(PIX_ADDR), .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
        .SCLK(SCLK), .LAT(LAT), .BLANK(BLANK), .ROW_ADDR(ROW_ADDR),
        .PLANE_START(PLANE_START), .PLANE(PLANE)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) PIX_DATA <= mem[PIX_ADDR];
    assign rgb = {R1, G1, B1, R2, G2, B2};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Runs n cycles, logging output activity relative to base; pulse_m bit r drives PLANE_DONE into edge base+r.
    task automatic observe(input int n, input int base, input logic [63:0] pulse_m);
        int rel;
        sclk_m = '0; lat_m = '0; start_m = '0; blank_m = '0;
        sclk_n = 0;  lat_n = 0;  start_n = 0;  blank_n = 0;
        rgb9 = 'x; addr6 = 'x; addr_s = 'x; plane_s = 'x; row_s = 'x;
        for (int i = 0; i < n; i++) begin
            tick();
            rel = cyc - base;
            if (SCLK) begin
                sclk_n++;
                sclk_m |= 64'd1 << rel;
                if (rel == 9) rgb9 = rgb;
            end
            if (LAT) begin
                lat_n++;
                lat_m |= 64'd1 << rel;
            end
            if (BLANK) begin
                blank_n++;
                blank_m |= 64'd1 << rel;
            end
            if (PLANE_START) begin
                start_n++;
                start_m |= 64'd1 << rel;
                plane_s = PLANE;
                row_s   = ROW_ADDR;
                addr_s  = PIX_ADDR;
            end
            if (rel == 6) addr6 = PIX_ADDR;
            PLANE_DONE = |((pulse_m >> (rel + 1)) & 64'd1);
        end
    endtask

    initial begin
        for (int a = 0; a < 8; a++) mem[a] = 12'h000;
        mem[1] = 12'hFFF;
        mem[2] = 12'hA5C;
        mem[5] = 12'hFFF;
        mem[6] = 12'h3C9;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        cyc = 0;
        chk("rst_blank", 64'(BLANK), 64'd1);
        chk("rst_sclk", 64'(SCLK), 64'd0);
        chk("rst_lat", 64'(LAT), 64'd0);
        chk("rst_start", 64'(PLANE_START), 64'd0);
        chk("rst_addr", 64'(PIX_ADDR), 64'd0);
        chk("rst_rgb", 64'(rgb), 64'd0);
        chk("rst_row_plane", 64'({ROW_ADDR, PLANE}), 64'd0);
        RST = 1'b0;

        // First plane after reset: row 0, plane 0, no wait
        observe(15, 0, 64'd0);
        chk("p0_sclk_rises", sclk_m, 64'h1248);
        chk("p0_sclk_count", 64'(sclk_n), 64'd4);
        chk("p0_lat", lat_m, 64'h4000);
        chk("p0_start", start_m, 64'h8000);
        chk("p0_blank", blank_m, 64'h7FFE);
        chk("p0_col2_addr", 64'(addr6), 64'd2);
        chk("p0_col2_rgb", 64'(rgb9), 64'h0E);
        chk("p0_plane_row", 64'({plane_s, row_s}), 64'd0);

        // Row 0 plane 1, then PLANE_DONE withheld for 100 cycles
        observe(12, 15, 64'd0);
        chk("p1_sclk_rises", sclk_m, 64'h1248);
        chk("p1_col2_rgb", 64'(rgb9), 64'h32);
        chk("p1_blank", blank_m, 64'd0);
        observe(100, 27, 64'd0);
        chk("wait_sclk", 64'(sclk_n), 64'd0);
        chk("wait_lat", 64'(lat_n), 64'd0);
        chk("wait_blank", 64'(blank_n), 64'd0);
        chk("wait_start", 64'(start_n), 64'd0);
        PLANE_DONE = 1'b1;
        observe(4 + DT, 127, 64'd0);
        chk("wait_lat_t2", lat_m, 64'd1 << (3 + DT));
        chk("wait_start_t3", start_m, 64'd1 << (4 + DT));
        chk("wait_blank_win", blank_m, ((64'd1 << (2 + DT)) - 64'd1) << 2);
        chk("wait_plane_row", 64'({plane_s, row_s}), 64'b10);
        chk("wait_next_addr", 64'(addr_s), 64'd4);

        // Row 1 plane 0: PLANE_DONE mid-shift (twice), then a pulse during UNBLANK
        s = cyc;
        observe(15, s, 64'h8050);
        chk("mid_sclk_rises", sclk_m, 64'h1248);
        chk("mid_lat", lat_m, 64'h4000);
        chk("mid_start", start_m, 64'h8000);
        chk("mid_blank", blank_m, 64'h6000);
        chk("mid_col2_addr", 64'(addr6), 64'd6);
        chk("mid_col2_rgb", 64'(rgb9), 64'h19);
        chk("mid_plane_row", 64'({plane_s, row_s}), 64'b01);
        chk("mid_next_addr", 64'(addr_s), 64'd4);

        // Row 1 plane 1: the UNBLANK pulse must have been dropped
        s2 = cyc;
        observe(20, s2, 64'd0);
        chk("drop_sclk_rises", sclk_m, 64'h1248);
        chk("drop_col2_rgb", 64'(rgb9), 64'h1A);
        chk("drop_lat", 64'(lat_n), 64'd0);
        chk("drop_blank", 64'(blank_n), 64'd0);
        PLANE_DONE = 1'b1;
        observe(4 + DT, s2 + 20, 64'd0);
        chk("wrap_lat", lat_m, 64'd1 << (3 + DT));
        chk("wrap_start", start_m, 64'd1 << (4 + DT));
        chk("wrap_blank_cycles", 64'(blank_n), 64'(2 + DT));
        chk("wrap_plane_row", 64'({plane_s, row_s}), 64'b11);
        chk("wrap_row_addr_field", 64'(addr_s), 64'd0);

        // Reset during the column 2 shift
        s3 = cyc;
        observe(8, s3, 64'd0);
        RST = 1'b1;
        tick();
        chk("mrst_blank", 64'(BLANK), 64'd1);
        chk("mrst_sclk", 64'(SCLK), 64'd0);
        chk("mrst_addr", 64'(PIX_ADDR), 64'd0);
        chk("mrst_rgb", 64'(rgb), 64'd0);
        chk("mrst_row_plane", 64'({ROW_ADDR, PLANE}), 64'd0);
        RST = 1'b0;
        observe(15, cyc, 64'd0);
        chk("restart_sclk_rises", sclk_m, 64'h1248);
        chk("restart_lat", lat_m, 64'h4000);
        chk("restart_start", start_m, 64'h8000);
        chk("restart_blank", blank_m, 64'h7FFE);
        chk("restart_col2_rgb", 64'(rgb9), 64'h0E);
        chk("restart_plane_row", 64'({plane_s, row_s}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
